xadc_multi_channel_classifier: RTL and testbench
================================================

XADC_MULTI_CHANNEL_CLASSIFIER -- requirements
Module: xadc_multi_channel_classifier

Interface
REQ-001 Parameter NUM_CH, default 4, number of neuron output channels swept (legal 2..16).
REQ-002 Parameter BASE_ADDR, default 7'h10, DRP address of channel 0; channel k is at BASE_ADDR+k.
REQ-003 Parameter AVG_LOG2, default 2, log2 of sweeps averaged per decision (legal 0..4).
REQ-004 Parameter TIMEOUT, default 64, maximum cycles waiting for DRDY.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 enable  in  1  level; 1 = run sweeps.
REQ-008 sample_period  in  16  idle cycles between sweep starts.
REQ-009 threshold  in  12  minimum winning average for a valid spike.
REQ-010 DADDR  out  7  DRP address.
REQ-011 DEN  out  1  DRP enable, one-cycle pulse.
REQ-012 DWE  out  1  DRP write enable, tied 0.
REQ-013 DI  out  16  DRP write data, tied 0.
REQ-014 DO  in  16  DRP read data; sample is DO[15:4].
REQ-015 DRDY  in  1  DRP read-data valid.
REQ-016 result  out  CW=$clog2(NUM_CH)  winning channel index.
REQ-017 result_valid  out  1  one-cycle pulse per decision.
REQ-018 no_spike  out  1  1 when last winning average < threshold.
REQ-019 busy  out  1  1 in any state except IDLE.
REQ-020 timeout_err  out  1  sticky DRP timeout flag.

Function
REQ-021 FSM states: IDLE, WAIT_PERIOD, REQ, WAIT_DRDY, NEXT, COMPARE, DONE.
REQ-022 IDLE -> REQ when enable=1; channel index and sweep counter cleared, accumulators zeroed.
REQ-023 REQ drives DEN=1 for exactly one cycle with DADDR=BASE_ADDR+ch, then WAIT_DRDY.
REQ-024 DRDY SHALL be accepted only in WAIT_DRDY; on DRDY, DO[15:4] is added to acc[ch] (width 12+AVG_LOG2, no overflow possible), then NEXT.
REQ-025 NEXT: if ch<NUM_CH-1, ch+1 and REQ; else if sweep<2^AVG_LOG2-1, sweep+1, ch=0, WAIT_PERIOD; else COMPARE.
REQ-026 WAIT_PERIOD counts sample_period cycles then enters REQ; sample_period=0 SHALL go to REQ the next cycle.
REQ-027 COMPARE: avg[k]=acc[k]>>AVG_LOG2; result=argmax avg, ties to lowest index; no_spike=(avg[result]<threshold); takes NUM_CH cycles (sequential compare, one channel per cycle).
REQ-028 DONE: result_valid=1 for one cycle, result/no_spike updated same cycle and held until next decision; then WAIT_PERIOD (enable=1) or IDLE (enable=0); accumulators zeroed.
REQ-029 DADDR SHALL hold its value outside REQ; DEN=0 outside REQ.
REQ-030 enable falling mid-round: an outstanding DRP read completes (or times out), then IDLE; partial accumulation discarded, no result_valid.
REQ-031 No DRDY within TIMEOUT cycles of DEN: timeout_err set, round aborted, IDLE; accumulators zeroed; timeout_err cleared only by reset.
REQ-032 DRDY arriving on the same cycle as timeout expiry SHALL be accepted as valid data (no timeout).

Reset
REQ-033 rst_n=0 at a clock edge: state IDLE, DADDR=BASE_ADDR, DEN=0, result=0, result_valid=0, no_spike=1, busy=0, timeout_err=0, all counters/accumulators 0; applies mid-transaction, DRDY then ignored.

Configuration
REQ-034 Macro XADC_CLASSIFIER_LEVEL_OUT_EN defined: extra output win_level[11:0] = avg[result], updated with result, reset 0; undefined: port and logic absent, all other behaviour identical.

Verification
REQ-035 NUM_CH=4, AVG_LOG2=0, DO[15:4]=100,900,300,50 -> DADDR 10,11,12,13 in order, result=1, no_spike=0 with threshold=500, one result_valid pulse.
REQ-036 AVG_LOG2=2, ch2 samples 800,800,800,804, others 100, threshold 900 -> result=2, no_spike=1, win_level=801 when macro defined.
REQ-037 Equal averages 400 on ch1 and ch3 -> result=1.
REQ-038 DRDY withheld after ch0 DEN -> timeout_err=1 exactly TIMEOUT cycles later, busy=0, no result_valid; stays 1 until rst_n.
REQ-039 sample_period=10, enable held -> consecutive sweep first-DEN spacing = 10 + sweep duration cycles; sample_period=0 -> REQ one cycle after NEXT.
REQ-040 enable dropped during ch2 read; rst_n pulsed during a later read -> first: read completes, IDLE, no result_valid; second: all outputs at REQ-033 values next cycle.

Source files
------------

// File: rtl/xadc_multi_channel_classifier.sv
// Sweeps NUM_CH XADC channels over the DRP, averages 2^AVG_LOG2 sweeps per channel and
// reports the strongest channel. Optional win_level output under XADC_CLASSIFIER_LEVEL_OUT_EN.
module xadc_multi_channel_classifier #(
  parameter int         NUM_CH    = 4,
  parameter logic [6:0] BASE_ADDR = 7'h10,
  parameter int         AVG_LOG2  = 2,
  parameter int         TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [15:0]               sample_period,
  input  logic [11:0]               threshold,
  output logic [6:0]                DADDR,
  output logic                      DEN,
  output logic                      DWE,
  output logic [15:0]               DI,
  input  logic [15:0]               DO,
  input  logic                      DRDY,
  output logic [$clog2(NUM_CH)-1:0] result,
  output logic                      result_valid,
  output logic                      no_spike,
  output logic                      busy,
`ifdef XADC_CLASSIFIER_LEVEL_OUT_EN
  output logic [11:0]               win_level,
`endif
  output logic                      timeout_err
);

  localparam int         CW         = $clog2(NUM_CH);
  localparam int         ACC_W      = 12 + AVG_LOG2;
  localparam int         TW         = $clog2(TIMEOUT + 1);
  localparam logic [4:0] SWEEP_LAST = 5'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_PERIOD, REQ, WAIT_DRDY, NEXT, COMPARE, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    ch, cmp_idx, best_idx, fin_idx;
  logic [4:0]       sweep;
  logic [15:0]      wcnt;
  logic [TW-1:0]    tmr;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [11:0]      best_val, cand_val, fin_val;
  logic [6:0]       daddr_hold;
  logic             ch_last, cmp_last, take_cand, period_done, tmr_exp;
  logic             unused_do_bits;

  function automatic logic [11:0] avg_of(input logic [ACC_W-1:0] a);
    return 12'(a >> AVG_LOG2);
  endfunction

  assign unused_do_bits = ^DO[3:0];

  assign ch_last     = (ch == CW'(NUM_CH - 1));
  assign cmp_last    = (cmp_idx == CW'(NUM_CH - 1));
  assign period_done = (({1'b0, wcnt} + 17'd1) >= {1'b0, sample_period});
  assign tmr_exp     = (tmr == TW'(TIMEOUT - 1));

  // Running argmax: strict '>' keeps the lowest index on ties.
  assign cand_val  = avg_of(acc[cmp_idx]);
  assign take_cand = (cmp_idx == CW'(0)) || (cand_val > best_val);
  assign fin_idx   = take_cand ? cmp_idx : best_idx;
  assign fin_val   = take_cand ? cand_val : best_val;

  assign DEN          = (state == REQ);
  assign DWE          = 1'b0;
  assign DI           = 16'h0000;
  assign DADDR        = (state == REQ) ? (BASE_ADDR + 7'(ch)) : daddr_hold;
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (enable) state_nxt = REQ;
      WAIT_PERIOD: begin
        if (!enable)          state_nxt = IDLE;
        else if (period_done) state_nxt = REQ;
      end
      REQ:         state_nxt = WAIT_DRDY;
      WAIT_DRDY: begin
        if (DRDY)         state_nxt = NEXT;
        else if (tmr_exp) state_nxt = IDLE;
      end
      NEXT: begin
        if (!enable)                  state_nxt = IDLE;
        else if (!ch_last)            state_nxt = REQ;
        else if (sweep != SWEEP_LAST) state_nxt = (sample_period == 16'd0) ? REQ : WAIT_PERIOD;
        else                          state_nxt = COMPARE;
      end
      COMPARE:     if (cmp_last) state_nxt = DONE;
      DONE: begin
        if (!enable) state_nxt = IDLE;
        else         state_nxt = (sample_period == 16'd0) ? REQ : WAIT_PERIOD;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      daddr_hold  <= BASE_ADDR;
      ch          <= '0;
      sweep       <= '0;
      wcnt        <= '0;
      tmr         <= '0;
      cmp_idx     <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      result      <= '0;
      no_spike    <= 1'b1;
      timeout_err <= 1'b0;
`ifdef XADC_CLASSIFIER_LEVEL_OUT_EN
      win_level   <= '0;
`endif
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
    end else begin
      state      <= state_nxt;
      daddr_hold <= DADDR;
      case (state)
        IDLE: begin
          ch    <= '0;
          sweep <= '0;
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        end
        WAIT_PERIOD: wcnt <= wcnt + 16'd1;
        REQ:         tmr <= '0;
        WAIT_DRDY: begin
          // Data arriving on the expiry cycle still wins over the timeout.
          if (DRDY) begin
            acc[ch] <= acc[ch] + ACC_W'(DO[15:4]);
          end else if (tmr_exp) begin
            timeout_err <= 1'b1;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        NEXT: begin
          if (!ch_last) begin
            ch <= ch + CW'(1);
          end else if (sweep != SWEEP_LAST) begin
            sweep <= sweep + 5'd1;
            ch    <= '0;
          end
          cmp_idx <= '0;
          wcnt    <= '0;
        end
        COMPARE: begin
          best_idx <= fin_idx;
          best_val <= fin_val;
          cmp_idx  <= cmp_idx + CW'(1);
          if (cmp_last) begin
            result   <= fin_idx;
            no_spike <= (fin_val < threshold);
`ifdef XADC_CLASSIFIER_LEVEL_OUT_EN
            win_level <= fin_val;
`endif
          end
        end
        DONE: begin
          ch    <= '0;
          sweep <= '0;
          wcnt  <= '0;
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_multi_channel_classifier.sv
// Randomized bench for xadc_multi_channel_classifier: a DRP responder serves sample tables
// and a plain-arithmetic averaging/argmax model predicts each decision.
module tb_xadc_multi_channel_classifier;

  localparam int NCH = 4;
  localparam int AL  = 2;
  localparam int NSW = 4;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_period = '0;
  logic [11:0] threshold = '0;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic [1:0]  result;
  logic        result_valid, no_spike, busy, timeout_err;

  always #5 clk = ~clk;

  xadc_multi_channel_classifier #(
    .NUM_CH(NCH), .BASE_ADDR(7'h10), .AVG_LOG2(AL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_period(sample_period),
    .threshold(threshold), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO),
    .DRDY(DRDY), .result(result), .result_valid(result_valid), .no_spike(no_spike),
    .busy(busy), .timeout_err(timeout_err)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [11:0] samp [NSW][NCH];
  int          hits [NCH];
  int          addr_q[$];
  int          den_cyc[$];
  int          cyc = 0;
  int          rv_cnt = 0;
  int          lat_mode = 0;
  int          lat_fix = 1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (result_valid === 1'b1) rv_cnt <= rv_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // DRP slave: answers each DEN after a latency; latencies beyond TO are never answered.
  initial begin
    int a, c, s, l;
    forever begin
      @(negedge clk);
      DRDY = 1'b0;
      if (DEN === 1'b1) begin
        a = int'(DADDR);
        addr_q.push_back(a);
        den_cyc.push_back(cyc);
        c = (a - 16) & 3;
        s = hits[c] % NSW;
        hits[c]++;
        l = (lat_mode == 0) ? int'($urandom_range(1, TO)) : lat_fix;
        if (l <= TO) begin
          repeat (l) @(negedge clk);
          DO   = {samp[s][c], 4'($urandom)};
          DRDY = 1'b1;
        end
      end
    end
  end

  function automatic void model(input int thr, output int r, output int ns);
    int best, sum, avg;
    best = -1;
    r    = 0;
    for (int k = 0; k < NCH; k++) begin
      sum = 0;
      for (int s = 0; s < NSW; s++) sum += int'(samp[s][k]);
      avg = sum / NSW;
      if (avg > best) begin
        best = avg;
        r    = k;
      end
    end
    ns = (best < thr) ? 1 : 0;
  endfunction

  task automatic clear_round();
    for (int k = 0; k < NCH; k++) hits[k] = 0;
    addr_q.delete();
    den_cyc.delete();
  endtask

  task automatic run_round(input string tag, input int thr, input int per);
    int  r_exp, ns_exp, rv0, errs;
    bit  seen;
    model(thr, r_exp, ns_exp);
    threshold     = 12'(thr);
    sample_period = 16'(per);
    clear_round();
    @(negedge clk);
    rv0    = rv_cnt;
    enable = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) seen = 1'b1;
    end
    enable = 1'b0;
    chk({tag, "_decision_seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, "_result"}, int'(result), r_exp);
      chk({tag, "_no_spike"}, int'(no_spike), ns_exp);
      chk({tag, "_reads"}, addr_q.size(), NCH * NSW);
      errs = 0;
      foreach (addr_q[i]) if (addr_q[i] != 16 + (i % NCH)) errs++;
      chk({tag, "_addr_order"}, errs, 0);
    end
    repeat (3) @(negedge clk);
    chk({tag, "_idle_after"}, int'(busy), 0);
    chk({tag, "_one_pulse"}, rv_cnt - rv0, 1);
    chk({tag, "_result_held"}, int'(result), r_exp);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_daddr"}, int'(DADDR), 16);
    chk({tag, "_den"}, int'(DEN), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_no_spike"}, int'(no_spike), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tmo"}, int'(timeout_err), 0);
  endtask

  initial begin
    int  rv0, t_cyc, i_tie, j_tie;
    bit  seen;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    chk("dwe_tied", int'(DWE), 0);
    chk("di_tied", int'(DI), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Strongest channel 1 at 900 against threshold 500.
    for (int s = 0; s < NSW; s++) begin
      samp[s][0] = 12'd100; samp[s][1] = 12'd900; samp[s][2] = 12'd300; samp[s][3] = 12'd50;
    end
    run_round("basic", 500, 2);
    chk("basic_const_result", int'(result), 1);

    // Channel 2 averages 801, below threshold 900.
    for (int s = 0; s < NSW; s++) for (int k = 0; k < NCH; k++) samp[s][k] = 12'd100;
    samp[0][2] = 12'd800; samp[1][2] = 12'd800; samp[2][2] = 12'd800; samp[3][2] = 12'd804;
    run_round("avg", 900, 1);
    chk("avg_const_nospike", int'(no_spike), 1);

    // Tie between channels 1 and 3 resolves to 1.
    for (int s = 0; s < NSW; s++) begin
      samp[s][0] = 12'd100; samp[s][1] = 12'd400; samp[s][2] = 12'd200; samp[s][3] = 12'd400;
    end
    run_round("tie", 300, 0);
    chk("tie_const_result", int'(result), 1);

    // Sweep spacing with a fixed DRP latency of 3.
    lat_mode = 1;
    lat_fix  = 3;
    run_round("space10", 2000, 10);
    if (den_cyc.size() >= 9) begin
      chk("space10_s0s1", den_cyc[4] - den_cyc[0], NCH * (3 + 2) + 10);
      chk("space10_s1s2", den_cyc[8] - den_cyc[4], NCH * (3 + 2) + 10);
    end else chk("space10_dens", den_cyc.size(), 16);
    run_round("space0", 2000, 0);
    if (den_cyc.size() >= 5) chk("space0_s0s1", den_cyc[4] - den_cyc[0], NCH * (3 + 2));
    else chk("space0_dens", den_cyc.size(), 16);
    lat_mode = 0;

    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < NSW; s++) for (int k = 0; k < NCH; k++) samp[s][k] = 12'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        i_tie = $urandom_range(0, NCH - 1);
        j_tie = $urandom_range(0, NCH - 1);
        for (int s = 0; s < NSW; s++) samp[s][j_tie] = samp[s][i_tie];
      end
      run_round($sformatf("rnd%0d", n), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4)));
    end

    // Enable dropped while channel 2 is being read.
    lat_mode = 1;
    lat_fix  = 8;
    sample_period = 16'd0;
    clear_round();
    rv0    = rv_cnt;
    enable = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (addr_q.size() >= 3) seen = 1'b1;
    end
    enable = 1'b0;
    chk("drop_reached_ch2", int'(seen), 1);
    repeat (15) @(negedge clk);
    chk("drop_busy", int'(busy), 0);
    chk("drop_reads", addr_q.size(), 3);
    chk("drop_no_rv", rv_cnt - rv0, 0);
    chk("drop_daddr_hold", int'(DADDR), 8'h12);

    // Reset pulsed mid-read; the late DRDY must be ignored.
    lat_fix = 6;
    clear_round();
    rv0    = rv_cnt;
    enable = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (addr_q.size() >= 2) seen = 1'b1;
    end
    chk("rstmid_reached", int'(seen), 1);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_reset_vals("rstmid");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_busy_after", int'(busy), 0);
    chk("rstmid_no_rv", rv_cnt - rv0, 0);

    // Withheld DRDY: timeout, abort, sticky flag.
    lat_fix = TO + 5;
    clear_round();
    rv0    = rv_cnt;
    enable = 1'b1;
    seen   = 1'b0;
    t_cyc  = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        seen  = 1'b1;
        t_cyc = cyc;
      end
    end
    chk("tmo_seen", int'(seen), 1);
    chk("tmo_busy", int'(busy), 0);
    enable = 1'b0;
    if (den_cyc.size() > 0) chk("tmo_delay", t_cyc - den_cyc[0], TO + 1);
    else chk("tmo_den_seen", 0, 1);
    repeat (5) @(negedge clk);
    chk("tmo_sticky", int'(timeout_err), 1);
    chk("tmo_no_rv", rv_cnt - rv0, 0);
    chk("tmo_reads", addr_q.size(), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("tmo_cleared", int'(timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
